// File: rtl/vec_test_sequencer.sv
// Drives a deterministic lane-vector sequence through a DUT and checks each echoed response.
// 3 cycles/vector with a zero-wait DUT; holds req_data under backpressure, aborts on per-vector timeout.
module vec_test_sequencer #(
  parameter int NUM_VECTORS = 8,
  parameter int LANES       = 4,
  parameter int WIDTH       = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [LANES*WIDTH-1:0] req_data,
  input  logic                   rsp_valid,
  output logic                   rsp_ready,
  input  logic [LANES*WIDTH-1:0] rsp_data,
  output logic [7:0]             vec_idx,
  output logic [7:0]             err_count,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   timed_out
);
  localparam int              DW       = LANES * WIDTH;
  localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [7:0]      LAST_IDX = 8'(NUM_VECTORS - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [DW-1:0]   rsp_cap;
  logic [DW-1:0]   stim;
  logic            last_vec;
  logic            tmo;

  // Stimulus is a pure function of vec_idx, so no pattern memory is needed.
  always_comb begin
    logic [31:0] lane_val;
    lane_val = '0;
    stim     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_val = 32'(vec_idx) * 32'(LANES) + 32'(i);
      stim[i*WIDTH +: WIDTH] = lane_val[WIDTH-1:0];
    end
  end

  assign last_vec = (vec_idx == LAST_IDX);
  // A handshake on the final allowed cycle takes priority over the timeout.
  assign tmo = (timer == TMO_LAST) &&
               (((state == S_DRIVE) && !req_ready) || ((state == S_WAIT) && !rsp_valid));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
      S_DRIVE: begin
        if (req_ready)  state_nxt = S_WAIT;
        else if (tmo)   state_nxt = S_DONE;
      end
      S_WAIT: begin
        if (rsp_valid)  state_nxt = S_CHECK;
        else if (tmo)   state_nxt = S_DONE;
      end
      S_CHECK: state_nxt = last_vec ? S_DONE : S_DRIVE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state == S_DRIVE);
    rsp_ready = (state == S_WAIT);
    busy      = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    done      = (state == S_DONE);
    req_data  = req_valid ? stim : '0;
    pass      = done && (err_count == 8'd0) && !timed_out;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vec_idx   <= '0;
      err_count <= '0;
      timed_out <= 1'b0;
      timer     <= '0;
      rsp_cap   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_idx   <= '0;
            err_count <= '0;
            timed_out <= 1'b0;
            timer     <= '0;
          end
        end
        S_DRIVE: begin
          if (req_ready) timer <= '0;
          else           timer <= timer + TW'(1);
          if (tmo) timed_out <= 1'b1;
        end
        S_WAIT: begin
          if (rsp_valid) begin
            timer   <= '0;
            rsp_cap <= rsp_data;
          end else begin
            timer <= timer + TW'(1);
          end
          if (tmo) timed_out <= 1'b1;
        end
        S_CHECK: begin
          if ((rsp_cap != stim) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
          if (!last_vec) vec_idx <= vec_idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_test_sequencer.sv
// Scoreboarded bench: loopback responder with selectable backpressure, expected requests and verdicts queued.
module tb_vec_test_sequencer;
  logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic        req_valid, rsp_ready;
  logic        req_ready = 1'b0, rsp_valid = 1'b0;
  logic [31:0] req_data;
  logic [31:0] rsp_data = '0;
  logic [7:0]  vec_idx, err_count;
  logic        busy, done, pass, timed_out;

  typedef struct packed {
    logic [7:0] err;
    logic       pass;
    logic       to;
    logic [7:0] idx;
  } verdict_t;

  logic [31:0] exp_req[$];
  verdict_t    exp_vd[$];
  verdict_t    vd_e;
  int          n_checks = 0, n_fail = 0;

  // Responder configuration: 0 zero-wait loopback, 1 random stalls, 2 one-cycle request stall with junk rsp_data
  int          mode = 0;
  int          stuck_idx = 256;
  logic [7:0]  corrupt = '0;
  logic        pending = 1'b0, drive_seen = 1'b0, prev_stall = 1'b0, done_prev = 1'b0;
  logic [31:0] prev_data = '0, v2_data = '0, v7_data = '0;
  int          req_lo = 0, rsp_lo = 0;

  vec_test_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .vec_idx(vec_idx), .err_count(err_count), .busy(busy), .done(done),
    .pass(pass), .timed_out(timed_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_vec(input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(k * 4 + i);
    return v;
  endfunction

  task automatic push_reqs(input int n);
    for (int k = 0; k < n; k++) exp_req.push_back(exp_vec(k));
  endtask

  task automatic push_vd(input int err, input bit p, input bit to, input int idx);
    verdict_t v;
    v.err = 8'(err); v.pass = p; v.to = to; v.idx = 8'(idx);
    exp_vd.push_back(v);
  endtask

  // Responder and monitor share one negedge process so handshake decisions and checks see the same values.
  always @(negedge clock) begin
    if (mode == 1) begin
      rsp_valid = pending && (rsp_lo >= 10 || $urandom_range(0, 2) == 0);
      rsp_lo    = (pending && !rsp_valid) ? rsp_lo + 1 : 0;
    end else begin
      rsp_valid = 1'b1;
    end
    if (rsp_valid && rsp_ready) pending = 1'b0;

    if (mode == 1) begin
      req_ready = (req_lo >= 10) || ($urandom_range(0, 2) == 0);
      req_lo    = (req_valid && !req_ready) ? req_lo + 1 : 0;
    end else if (mode == 2) begin
      req_ready  = req_valid && drive_seen;
      drive_seen = req_valid;
    end else begin
      req_ready = (int'(vec_idx) < stuck_idx);
    end

    if (prev_stall && req_valid) chk("req_data_stable", req_data, prev_data);
    prev_stall = req_valid && !req_ready;
    prev_data  = req_data;

    if (req_valid && req_ready) begin
      pending  = 1'b1;
      rsp_data = req_data ^ (corrupt[vec_idx[2:0]] ? 32'h0000_FF00 : 32'h0);
      if (vec_idx == 8'd2) v2_data = req_data;
      if (vec_idx == 8'd7) v7_data = req_data;
      if (exp_req.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_request: got 0x%0h at vec_idx %0d, expected none", req_data, vec_idx);
      end else begin
        chk("req_data", req_data, exp_req.pop_front());
      end
    end else if (mode == 2 && !rsp_ready) begin
      rsp_data = 32'hDEAD_BEEF;
    end

    if (done && !done_prev) begin
      if (exp_vd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done with err_count %0d, expected no verdict", err_count);
      end else begin
        vd_e = exp_vd.pop_front();
        chk("err_count", err_count, vd_e.err);
        chk("pass", pass, vd_e.pass);
        chk("timed_out", timed_out, vd_e.to);
        chk("vec_idx_done", vec_idx, vd_e.idx);
      end
    end
    done_prev = done;
  end

  task automatic run_test(input int exp_cyc, input int exp_to_cyc, input bit pulse);
    int cyc, t_enter;
    cyc = 0; t_enter = -1;
    @(negedge clock);
    start = 1'b1;
    while (1) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 1)
        chk("start_state", {req_valid, busy, done, pass, timed_out, err_count, vec_idx},
            {5'b11000, 8'd0, 8'd0});
      if (req_valid && vec_idx == 8'd4 && t_enter < 0) t_enter = cyc;
      if (done) break;
      start = pulse && (cyc % 3 == 0);
      if (cyc >= 1000) begin
        n_checks++; n_fail++;
        $display("FAIL run_bound: got no done after %0d cycles, expected done", cyc);
        break;
      end
    end
    start = 1'b0;
    if (exp_cyc > 0)    chk("run_cycles", cyc, exp_cyc);
    if (exp_to_cyc > 0) chk("timeout_cycles", cyc - t_enter, exp_to_cyc);
    repeat (3) @(negedge clock);
    chk("done_hold", {done, busy, req_valid, rsp_ready}, 4'b1000);
    chk("req_queue_drained", exp_req.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {req_valid, rsp_ready, busy, done, pass, timed_out, vec_idx, err_count, req_data}, 64'd0);
    @(negedge clock) reset = 1'b1;

    // Zero-wait loopback
    push_reqs(8); push_vd(0, 1, 0, 7);
    run_test(25, 0, 0);
    chk("vec2_data", v2_data, 32'h0B0A_0908);
    chk("vec7_data", v7_data, 32'h1F1E_1D1C);

    // Lane 1 corrupted on vectors 3 and 5
    corrupt = 8'b0010_1000;
    push_reqs(8); push_vd(2, 0, 0, 7);
    run_test(25, 0, 0);
    corrupt = '0;

    // Random backpressure; restart from DONE must clear err_count
    mode = 1;
    push_reqs(8); push_vd(0, 1, 0, 7);
    run_test(0, 0, 0);

    // Request channel stuck from vector 4
    mode = 0; stuck_idx = 4;
    push_reqs(4); push_vd(0, 0, 1, 4);
    run_test(29, 16, 0);
    stuck_idx = 256;

    // start pulsed while busy, junk rsp_valid data outside WAIT
    mode = 2;
    push_reqs(8); push_vd(0, 1, 0, 7);
    run_test(33, 0, 1);
    mode = 0;

    // Reset during WAIT of vector 6, then a clean run
    push_reqs(7);
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    n = 0;
    while (!(rsp_ready && vec_idx == 8'd6) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL wait_vec6: got no WAIT on vector 6, expected it within 200 cycles");
    end
    #2 reset = 1'b0;
    #1 chk("reset_midrun", {req_valid, rsp_ready, busy, done, pass, timed_out, vec_idx, err_count, req_data}, 64'd0);
    @(negedge clock) reset = 1'b1;
    chk("req_queue_after_reset", exp_req.size(), 0);
    push_reqs(8); push_vd(0, 1, 0, 7);
    run_test(25, 0, 0);

    chk("verdict_queue_drained", exp_vd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vec_test_sequencer.md
# vec_test_sequencer

Self-checking stimulus sequencer for lane-vector connection tests. Generates a deterministic sequence of packed multi-lane vectors, pushes each into a device-under-test over a valid/ready request channel, collects the returned vector over a valid/ready response channel, compares it against what was sent, and reports a pass/fail verdict with an error count and a per-vector timeout. It sits beside the vector-connect testers in the test harness and replaces one-shot finish-on-reset checks with a sequenced, handshaked run.

## Interface

- NUM_VECTORS, 8, vectors per run (1..256)
- LANES, 4, lanes per vector (>=1)
- WIDTH, 8, bits per lane (1..16)
- TIMEOUT, 16, max cycles waiting in DRIVE or WAIT per vector (>=2)

- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  begin a run; sampled only in IDLE or DONE
- req_valid  out  1  request vector valid
- req_ready  in  1  DUT accepts request
- req_data  out  LANES*WIDTH  packed request, lane 0 at LSBs
- rsp_valid  in  1  DUT response valid
- rsp_ready  out  1  sequencer accepts response
- rsp_data  in  LANES*WIDTH  packed response, lane 0 at LSBs
- vec_idx  out  8  index of current vector
- err_count  out  8  mismatching vectors this run, saturates at 255
- busy  out  1  run in progress (DRIVE, WAIT, CHECK)
- done  out  1  run finished; held until next start
- pass  out  1  valid when done: err_count==0 and no timeout
- timed_out  out  1  valid when done: run aborted on timeout

## Operation

- States: IDLE, DRIVE, WAIT, CHECK, DONE. Reset -> IDLE.
- Stimulus: lane i of vector k = (k*LANES + i) mod 2^WIDTH; computed from vec_idx, no memory.
- IDLE/DONE + start=1 -> DRIVE; clears vec_idx, err_count, timed_out, pass, done, timer.
- DRIVE: req_valid=1, req_data stable. req_valid&req_ready -> WAIT, timer cleared.
- WAIT: rsp_ready=1. rsp_valid&rsp_ready -> capture rsp_data into register, -> CHECK, timer cleared.
- CHECK (one cycle): captured != expected for vec_idx -> err_count+1 (saturating). vec_idx==NUM_VECTORS-1 -> DONE; else vec_idx+1, -> DRIVE.
- Timer: counts cycles in DRIVE/WAIT; at TIMEOUT cycles without handshake -> DONE, timed_out=1, pass=0. vec_idx frozen at failing vector.
- DONE: done=1, pass = (err_count==0)&~timed_out. req_valid=rsp_ready=0.
- start while busy: ignored. rsp_valid outside WAIT: ignored, not counted.
- Responses strictly one per request; no overlap of requests.

## Timing

- Reset values: req_valid=0, rsp_ready=0, req_data=0, vec_idx=0, err_count=0, busy=0, done=0, pass=0, timed_out=0.
- Reset assertion mid-run: immediate return to IDLE, all outputs to reset values asynchronously.
- start at edge N -> req_valid=1 from edge N+1.
- Zero-wait DUT (req_ready=1, rsp_valid=1 always): 3 cycles per vector (DRIVE, WAIT, CHECK); full run = 3*NUM_VECTORS cycles after start, done=1 on following cycle.
- req_valid deasserts only after handshake; req_data may not change while req_valid=1 and req_ready=0.
- Timeout: handshake not seen in TIMEOUT consecutive DRIVE (or WAIT) cycles -> DONE next edge; handshake on cycle TIMEOUT itself wins over timeout.
- done, pass, timed_out, err_count hold in DONE until start or reset.

## Test plan

- Loopback DUT (rsp_data=last req_data, zero wait), defaults: start -> 8 vectors, vector 2 req_data=0x0B0A0908, done at cycle 25, pass=1, err_count=0.
- Corrupt response lane 1 of vectors 3 and 5 -> done, pass=0, err_count=2, timed_out=0.
- Random req_ready/rsp_valid backpressure (stall <=10 cycles) -> req_data stable under stall, pass=1, no timeout.
- req_ready held 0 from vector 4 -> DONE 16 cycles after entering DRIVE, timed_out=1, pass=0, vec_idx=4.
- Reset (0) during WAIT of vector 6 -> all outputs 0 same cycle; start after release -> clean run from vec_idx=0, pass=1.
- start pulsed while busy and spurious rsp_valid in DRIVE -> ignored, err_count=0, run completes; start in DONE restarts with counters cleared.
